// File: rtl/mips_cpu_mem_arbiter_pkg.sv
// Shared types for the data-side memory path.
// The state enum is also used by the write buffer.
package mips_cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_REQ  = 2'd2,
    RD_DATA = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Avalon-MM bus between the arbiter (master)
// and the memory system (slave).
interface mips_cpu_mem_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one Avalon master between write-buffer drain
// and cache line fills; reads win unless writes starve.
module mips_cpu_mem_arbiter
  import mips_cpu_mem_pkg::*;
#(
  parameter int LINE_BITS  = 2,
  parameter int STREAK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_empty,
  input  logic                 wb_full,
  input  logic                 wb_write,
  input  logic [31:0]          wb_addr,
  input  logic [31:0]          wb_writedata,
  input  logic [3:0]           wb_byteenable,
  output logic                 wb_active,
  output logic                 wb_waitrequest,
  input  logic                 rd_req,
  input  logic [31:0]          rd_addr,
  output logic                 rd_valid,
  output logic [LINE_BITS-1:0] rd_word,
  output logic [31:0]          rd_data,
  output logic                 rd_done,
  mips_cpu_mem_arbiter_if.master avm
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam int BW = 30 - LINE_BITS;
  localparam logic [LINE_BITS-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_MAX = SW'(STREAK_MAX);

  arb_state_t           state_q, state_d;
  logic [LINE_BITS-1:0] k_q, k_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic [BW-1:0]        base_q, base_d;
  logic                 wr_go;

  // State, word counter, streak and line base registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      streak_q <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      streak_q <= streak_d;
      base_q   <= base_d;
    end
  end

  // Arbitration, next state and bus steering.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    streak_d       = streak_q;
    base_d         = base_q;
    wr_go          = 1'b0;
    wb_active      = 1'b0;
    wb_waitrequest = 1'b1;
    rd_valid       = 1'b0;
    rd_word        = '0;
    rd_data        = '0;
    rd_done        = 1'b0;
    avm.address    = '0;
    avm.read       = 1'b0;
    avm.write      = 1'b0;
    avm.writedata  = '0;
    avm.byteenable = '0;
    unique case (state_q)
      IDLE: begin
        if (wb_full) begin
          wr_go = 1'b1;
        end else if (!wb_empty && streak_q == S_MAX) begin
          wr_go = 1'b1;
        end else if (rd_req) begin
          state_d = RD_REQ;
          base_d  = BW'(rd_addr >> (LINE_BITS + 2));
          k_d     = '0;
        end else if (!wb_empty) begin
          wr_go = 1'b1;
        end
        if (wr_go) begin
          state_d  = WR;
          streak_d = '0;
        end
      end
      WR: begin
        wb_active      = 1'b1;
        wb_waitrequest = avm.waitrequest;
        avm.write      = wb_write;
        avm.address    = wb_addr;
        avm.writedata  = wb_writedata;
        avm.byteenable = wb_byteenable;
        if ((wb_write && !avm.waitrequest) || wb_empty)
          state_d = IDLE;
      end
      RD_REQ: begin
        avm.read       = 1'b1;
        avm.address    = {base_q, k_q, 2'b00};
        avm.byteenable = 4'hF;
        if (!avm.waitrequest)
          state_d = RD_DATA;
      end
      RD_DATA: begin
        rd_valid = 1'b1;
        rd_word  = k_q;
        rd_data  = avm.readdata;
        if (k_q == K_LAST) begin
          rd_done = 1'b1;
          state_d = IDLE;
          if (!wb_empty && streak_q != S_MAX)
            streak_d = streak_q + SW'(1);
        end else begin
          k_d     = k_q + LINE_BITS'(1);
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
# mips_cpu_mem_arbiter

Owns the single Avalon memory master port and shares it between the data-cache write buffer (drain side) and the cache line-fill engine (read-miss side). Grants are issued one write word or one full line fill at a time. The write buffer is paused through its `active` input while a fill owns the bus. Read misses take priority, with two exceptions: a full write buffer always drains first, and a streak limit bounds how long pending writes can be starved.

## Interface
Parameters:
- LINE_BITS, 2: log2 words per cache line (LINE_WORDS = 2**LINE_BITS).
- STREAK_MAX, 4: maximum consecutive line fills granted while the write buffer is non-empty.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wb_empty  in  1  write buffer holds no entries.
- wb_full  in  1  write buffer full.
- wb_write  in  1  write buffer write-enable (write_writeenable).
- wb_addr  in  32  write buffer address.
- wb_writedata  in  32  write buffer data.
- wb_byteenable  in  4  write buffer byte enables.
- wb_active  out  1  drives write buffer `active`; high only in WR.
- wb_waitrequest  out  1  waitrequest returned to write buffer.
- rd_req  in  1  line fill request; held until rd_done.
- rd_addr  in  32  miss address; low LINE_BITS+2 bits ignored.
- rd_valid  out  1  rd_data valid this cycle.
- rd_word  out  LINE_BITS  word index of rd_data within the line.
- rd_data  out  32  fill data.
- rd_done  out  1  one-cycle pulse with the last rd_valid.
- avm_address  out  32, avm_read  out  1, avm_write  out  1, avm_writedata  out  32, avm_byteenable  out  4: Avalon master outputs.
- avm_readdata  in  32, avm_waitrequest  in  1: Avalon master inputs.

## Operation
- States: IDLE, WR, RD_REQ, RD_DATA. Registers: state, word counter k (LINE_BITS bits), streak counter (width clog2(STREAK_MAX+1)), latched line base.
- Arbitration happens only in IDLE, priority first match:
  - wb_full -> WR.
  - !wb_empty && streak==STREAK_MAX -> WR.
  - rd_req -> RD_REQ. Latch rd_addr[31:LINE_BITS+2], set k=0.
  - !wb_empty -> WR.
  - Otherwise stay in IDLE.
- WR:
  - wb_active=1.
  - avm_write=wb_write. avm_address, avm_writedata and avm_byteenable pass through from wb_*.
  - wb_waitrequest=avm_waitrequest.
  - Exit to IDLE when wb_write && !avm_waitrequest (one word transferred), or when wb_empty.
  - streak cleared to 0 on entry.
- RD_REQ:
  - avm_read=1, avm_address={base, k, 2'b00}, avm_byteenable=4'hF.
  - On !avm_waitrequest -> RD_DATA.
- RD_DATA:
  - rd_valid=1, rd_word=k, rd_data=avm_readdata (combinational).
  - If k==LINE_WORDS-1: rd_done=1, go to IDLE, streak increments (saturating at STREAK_MAX) only if wb_empty==0.
  - Else: k<=k+1, go to RD_REQ.
- Outside WR:
  - wb_active=0 and wb_waitrequest=1.
  - avm_write=0, avm_writedata=0.
- Outside RD_REQ: avm_read=0.
- Outside RD_DATA: rd_valid, rd_done, rd_data are 0.
- A fill is never pre-empted. A write word is never pre-empted once wb_write is high in WR.
- rd_req deasserting mid-fill is a protocol violation; the fill completes regardless.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, k=0, streak=0, base=0.
  - All outputs 0 except wb_waitrequest=1.
  - A transfer in flight is abandoned.
- Zero-wait-state costs:
  - Write word: 2 cycles (IDLE decision, WR transfer).
  - Line fill: 1 + 2*LINE_WORDS cycles from rd_req seen in IDLE to the cycle after rd_done. That is 9 cycles at LINE_BITS=2.
- Each wait-state cycle extends WR or RD_REQ by one cycle.
- Read data arrives in the cycle after the read is accepted (read && !waitrequest).
- Same-cycle rd_req and wb_full in IDLE: write wins. Same-cycle rd_req and a non-empty, non-full buffer with streak<STREAK_MAX: read wins.
- k wraps from LINE_WORDS-1 to 0 only through IDLE re-entry.

## Structure
- Package mips_cpu_mem_pkg: arb_state_t enum (IDLE=2'd0, WR=2'd1, RD_REQ=2'd2, RD_DATA=2'd3), shared with the write buffer's state typedef.
- Single module; no sub-module. The word counter and streak counter are inline.

## Test plan
- Write only: rd_req=0, buffer holds 3 entries, waitrequest=0. Expect 3 avm_write beats to wb_addr values, each 1 cycle long, separated by 1 IDLE cycle; then IDLE with wb_active=0.
- Fill, no waitstates: rd_req with rd_addr=0x0000_1234 and an empty buffer. Expect reads at 0x1230, 0x1234, 0x1238, 0x123C. Expect rd_valid with rd_word 0..3, and rd_done on word 3, 8 cycles after RD_REQ entry.
- Fill with waitrequest held for 2 cycles on word 1: avm_address=0x1234 stable across the stall; rd_data order unchanged.
- Priority and starvation: wb non-empty, not full, rd_req held continuously. Expect exactly 4 fills, then 1 write word, then fills resume. Separately, wb_full=1 with rd_req=1 in IDLE: WR is granted first.
- Asynchronous reset asserted mid-fill (RD_DATA, k=2): outputs drop within the same cycle with no clock edge. After release, a new rd_req restarts at k=0.
